// File: rtl/tx_enqueue_v2.sv
// tx_enqueue_v2 -- TX enqueue stage between the user packet interface and
// the TX data FIFO write port.
//
// Registers the FIFO write path (one cycle of latency), enforces SOP/EOP
// framing with a four-state FSM (IDLE, IN_PKT, ABORT, DROP) and truncates a
// packet with an error-tagged EOP word when the FIFO overflows, so that a
// corrupt frame never reaches the MAC unterminated.
//
// Build option:
//   TXENQ_BYTESWAP_EN  when defined, txdfifo_wdata byte order is reversed
//                      (byte 0 <-> byte DATA_W/8-1); mod is unchanged.
//                      When undefined, data passes through unchanged.
//
// Ports:
//   clk_156m25, reset_156m25_n      clock, async active-low reset
//   pkt_tx_data/val/sop/eop/mod      user packet input
//   pkt_tx_full                      copy of txdfifo_walmost_full
//   txdfifo_wfull, _walmost_full     FIFO fill state
//   txdfifo_wdata/wstatus/wen        registered FIFO write port
//                                    wstatus = {2'b0, ERR, SOP, EOP, mod[2:0]}
//   stat_clr                         synchronous clear of the counters
//   status_txdfifo_ovflow_tog        inverts once per overflow event
//   status_framing_err_tog           inverts once per framing error
//   stat_pkt_cnt, stat_drop_cnt      saturating packet counters
//   fsm_state                        debug view of the FSM state
//                                    (0 IDLE, 1 IN_PKT, 2 ABORT, 3 DROP)
//
// Handshake: a word is offered when pkt_tx_val=1; there is no per-word
// ready. pkt_tx_full (almost_full) asks the source to stop, and words that
// still arrive while txdfifo_wfull=1 are never written; the packet they
// belong to is truncated instead.

module tx_enqueue_v2 #(
  parameter int DATA_W = 64,
  parameter int MOD_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic [DATA_W-1:0] pkt_tx_data,
  input  logic              pkt_tx_val,
  input  logic              pkt_tx_sop,
  input  logic              pkt_tx_eop,
  input  logic [MOD_W-1:0]  pkt_tx_mod,
  output logic              pkt_tx_full,
  input  logic              txdfifo_wfull,
  input  logic              txdfifo_walmost_full,
  output logic [DATA_W-1:0] txdfifo_wdata,
  output logic [7:0]        txdfifo_wstatus,
  output logic              txdfifo_wen,
  input  logic              stat_clr,
  output logic              status_txdfifo_ovflow_tog,
  output logic              status_framing_err_tog,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic [CNT_W-1:0]  stat_drop_cnt,
  output logic [1:0]        fsm_state
);

  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    ABORT  = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   eop_seen, eop_seen_nxt;

  // Per-cycle decisions made by the output process.
  logic       wr_c;
  logic       wr_zero_c;   // write an all-zero data word (abort terminator)
  logic       wr_sop_c;
  logic       wr_eop_c;
  logic       wr_err_c;
  logic [2:0] wr_mod_c;
  logic       ovf_ev_c;
  logic       frm_ev_c;
  logic       good_pkt_c;
  logic       drop_pkt_c;

  logic [DATA_W-1:0] data_fmt;

  assign pkt_tx_full = txdfifo_walmost_full;
  assign fsm_state   = state;

`ifdef TXENQ_BYTESWAP_EN
  always_comb begin
    data_fmt = '0;
    for (int i = 0; i < NBYTES; i++) begin
      data_fmt[i*8 +: 8] = pkt_tx_data[(NBYTES-1-i)*8 +: 8];
    end
  end
`else
  assign data_fmt = pkt_tx_data;
`endif

  // State register.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state    <= IDLE;
      eop_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      eop_seen <= eop_seen_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    eop_seen_nxt = eop_seen;
    unique case (state)
      IDLE: begin
        if (pkt_tx_val && pkt_tx_sop) begin
          if (txdfifo_wfull) state_nxt = pkt_tx_eop ? IDLE : DROP;
          else               state_nxt = pkt_tx_eop ? IDLE : IN_PKT;
        end
      end
      IN_PKT: begin
        if (pkt_tx_val) begin
          if (txdfifo_wfull) begin
            state_nxt    = ABORT;
            eop_seen_nxt = pkt_tx_eop;
          end else if (pkt_tx_sop) begin
            state_nxt = pkt_tx_eop ? IDLE : DROP;
          end else if (pkt_tx_eop) begin
            state_nxt = IDLE;
          end
        end
      end
      ABORT: begin
        // An EOP arriving in the terminator cycle itself still counts.
        if (!txdfifo_wfull) begin
          state_nxt    = (eop_seen || (pkt_tx_val && pkt_tx_eop)) ? IDLE : DROP;
          eop_seen_nxt = 1'b0;
        end else if (pkt_tx_val && pkt_tx_eop) begin
          eop_seen_nxt = 1'b1;
        end
      end
      DROP: begin
        if (pkt_tx_val && pkt_tx_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decisions for this cycle; registered below.
  always_comb begin
    wr_c       = 1'b0;
    wr_zero_c  = 1'b0;
    wr_sop_c   = 1'b0;
    wr_eop_c   = 1'b0;
    wr_err_c   = 1'b0;
    wr_mod_c   = 3'd0;
    ovf_ev_c   = 1'b0;
    frm_ev_c   = 1'b0;
    good_pkt_c = 1'b0;
    drop_pkt_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (pkt_tx_val) begin
          if (!pkt_tx_sop) begin
            frm_ev_c = 1'b1;
          end else if (txdfifo_wfull) begin
            ovf_ev_c   = 1'b1;
            drop_pkt_c = 1'b1;
          end else begin
            wr_c     = 1'b1;
            wr_sop_c = 1'b1;
            if (pkt_tx_eop) begin
              wr_eop_c   = 1'b1;
              wr_mod_c   = 3'(pkt_tx_mod);
              good_pkt_c = 1'b1;
            end
          end
        end
      end
      IN_PKT: begin
        if (pkt_tx_val) begin
          if (txdfifo_wfull) begin
            ovf_ev_c = 1'b1;
          end else if (pkt_tx_sop) begin
            // The new SOP word closes the old packet as an errored EOP.
            frm_ev_c   = 1'b1;
            wr_c       = 1'b1;
            wr_eop_c   = 1'b1;
            wr_err_c   = 1'b1;
            drop_pkt_c = 1'b1;
          end else begin
            wr_c = 1'b1;
            if (pkt_tx_eop) begin
              wr_eop_c   = 1'b1;
              wr_mod_c   = 3'(pkt_tx_mod);
              good_pkt_c = 1'b1;
            end
          end
        end
      end
      ABORT: begin
        if (!txdfifo_wfull) begin
          wr_c       = 1'b1;
          wr_zero_c  = 1'b1;
          wr_eop_c   = 1'b1;
          wr_err_c   = 1'b1;
          drop_pkt_c = 1'b1;
        end
      end
      DROP: begin
        if (pkt_tx_val && pkt_tx_sop) frm_ev_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered FIFO write port, toggles and counters.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      txdfifo_wen               <= 1'b0;
      txdfifo_wdata             <= '0;
      txdfifo_wstatus           <= 8'd0;
      status_txdfifo_ovflow_tog <= 1'b0;
      status_framing_err_tog    <= 1'b0;
      stat_pkt_cnt              <= '0;
      stat_drop_cnt             <= '0;
    end else begin
      txdfifo_wen     <= wr_c;
      txdfifo_wdata   <= (wr_c && !wr_zero_c) ? data_fmt : '0;
      txdfifo_wstatus <= wr_c ? {2'b00, wr_err_c, wr_sop_c, wr_eop_c, wr_mod_c} : 8'd0;

      if (ovf_ev_c) status_txdfifo_ovflow_tog <= ~status_txdfifo_ovflow_tog;
      if (frm_ev_c) status_framing_err_tog    <= ~status_framing_err_tog;

      if (stat_clr)                        stat_pkt_cnt <= '0;
      else if (good_pkt_c && !(&stat_pkt_cnt)) stat_pkt_cnt <= stat_pkt_cnt + 1'b1;

      if (stat_clr)                          stat_drop_cnt <= '0;
      else if (drop_pkt_c && !(&stat_drop_cnt)) stat_drop_cnt <= stat_drop_cnt + 1'b1;
    end
  end

endmodule
